// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, responder states and alignment rule
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RSP,
        RMW_RD,
        RMW_WR,
        WACK,
        ERR
    } state_t;

    // Reserved size or an access not aligned to its own width is rejected.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_merge.sv
// rtl/byte_merge.sv - replaces the addressed byte/halfword lanes of a word with store data
module byte_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_WORD: merged_o = wdata_i;
            SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/mem_rmw_responder.sv
// rtl/mem_rmw_responder.sv - fixed-latency word memory responder with sub-word read-modify-write
module mem_rmw_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              accept;
    logic              req_bad;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       merged;
    logic              unused_ok;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = access_error(req_size, req_addr[1:0]);
    assign req_idx   = req_addr[ADDR_W+1:2];
    assign unused_ok = ^{req_addr[31:ADDR_W+2], we_q};

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    byte_merge u_byte_merge (
        .old_word_i (old_q),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .addr_lo_i  (lane_q),
        .merged_o   (merged)
    );

    // Storage is never cleared; reset only blocks a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept && !req_bad && req_we && (req_size == SZ_WORD)) begin
                mem_q[req_idx] <= req_wdata;
            end else if (state_q == RMW_WR) begin
                mem_q[idx_q] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_idx;
                        lane_q  <= req_addr[1:0];
                        we_q    <= req_we;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            state_q     <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state_q <= RD;
                        end else if (req_size == SZ_WORD) begin
                            state_q     <= WACK;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata_q <= mem_q[idx_q];
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RMW_RD: begin
                    old_q   <= mem_q[idx_q];
                    state_q <= RMW_WR;
                end
                RMW_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= WACK;
                end
                RSP, WACK, ERR: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_rmw_responder.md
Name: mem_rmw_responder

Overview:
Memory-side responder for the multicycle CPU's data/instruction port. It accepts one read or write request at a time and returns a fixed-latency response. It performs word stores directly. It performs halfword and byte stores with an internal read-modify-write. It flags misaligned accesses instead of performing them. Reads always return the full aligned word; sub-word extraction stays in the CPU's load path.

Parameters:
ADDR_W, 6, word-index width; storage is 2^ADDR_W 32-bit words (default 256 bytes)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present; requester holds all req_* stable until accepted
req_ready  output  1  high only in IDLE; accept = req_valid & req_ready
req_we  input  1  0 = read, 1 = write
req_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as error)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle pulse, no backpressure
rsp_err  output  1  valid with rsp_valid; 1 = misaligned/reserved, no side effect
rsp_rdata  output  32  aligned word for reads; holds last value otherwise

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Storage contents are not cleared.
  - Reset in any state aborts the in-flight request. A pending RMW_WR array write is suppressed; reset has priority.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Byte lane k = addr[1:0] occupies word bits [8k+7:8k] (little-endian). A halfword at addr[1]=h occupies bits [16h+15:16h].
- The request is captured into internal registers on accept (addr, we, size, wdata).
- Error check at accept. The request is an error if any of these hold:
  - word with addr[1:0]!=0;
  - halfword with addr[0]=1;
  - size=11.
- States:
  - IDLE: req_ready=1. On accept:
    - error -> ERR;
    - read -> RD;
    - word write -> the array is written in the accept cycle, then WACK;
    - half/byte write -> RMW_RD.
  - RD: register the array word into rsp_rdata -> RSP.
  - RSP: rsp_valid=1, rsp_err=0 -> IDLE.
  - RMW_RD: register the old word -> RMW_WR.
  - RMW_WR: write the merged word (replace only the addressed lanes with req_wdata low bits, other lanes unchanged) -> WACK.
  - WACK: rsp_valid=1, rsp_err=0 -> IDLE.
  - ERR: rsp_valid=1, rsp_err=1, no array access -> IDLE.
- Latency, with the accept at cycle T:
  - read: rsp_valid at T+2, with rsp_rdata valid that same cycle;
  - word write: rsp_valid at T+1, and the data is readable by a read accepted at T+2;
  - sub-word write: rsp_valid at T+3;
  - error: rsp_valid at T+1.
- req_ready is 0 in every state except IDLE. Requests offered then are not accepted and cause no side effect.
- A new request can be accepted in the cycle after rsp_valid (IDLE). Back-to-back operation has no bubble beyond that.
- Read-after-write to the same word always returns the newly written data, because writes complete before the response.
- rsp_rdata is updated only in RD. Write and error responses leave it unchanged.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state encoding (IDLE, RD, RSP, RMW_RD, RMW_WR, WACK, ERR), 3-bit.
- One natural sub-module: byte_merge. It is combinational; it takes the old word, wdata, size and addr[1:0], and outputs the merged word. It is reused later by the CPU-side store path.
- FSM, storage array and capture registers stay in mem_rmw_responder.

Test Plan:
- Reset, then a word write of 0xDEADBEEF to addr 0x10, then a read of 0x10 -> write rsp_valid at T+1 with rsp_err=0; read rsp_valid at T+2 with rsp_rdata=0xDEADBEEF; req_ready=0 during RD.
- Word 0x11223344 at 0x20, then byte write 0xAA to 0x21, then half write 0xBEEF to 0x22 -> each sub-word rsp_valid at T+3; a read of 0x20 returns 0xBEEFAA44.
- Misaligned cases: word write to 0x13, half read at 0x05, and size=11 -> each gives rsp_valid at T+1 with rsp_err=1; memory is unchanged and rsp_rdata keeps its prior value.
- Wrap-around with ADDR_W=6: write 0x55 (word) to 0x100 -> a read of 0x000 returns 0x00000055.
- Assert reset during RMW_WR of a byte write 0xFF to 0x30 (old 0x00000000) -> no rsp_valid; after reset a read of 0x30 returns 0x00000000.
- Hold req_valid with a second request while the first is busy -> the second is accepted in the first IDLE cycle after the response; exactly one response per request, in order.
